// File: rtl/mips_div_unit_pkg.sv
// Shared constants and state encoding for the MIPS multi-cycle divider.
package mips_div_unit_pkg;

   localparam int DIV_WIDTH = 32;

   // Width of an iteration counter that counts 0..w-1 (at least one bit).
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   localparam int CNT_W = cnt_width(DIV_WIDTH);

   // 2'b11 is unused and handled as IDLE by the controller.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_FIX  = 2'b10
   } div_state_t;

endpackage

// File: rtl/mips_div_unit_div_step.sv
// One restoring shift-subtract iteration. Shifts {rem, quo} left by one,
// then performs a trial subtraction of the divisor.
module mips_div_unit_div_step #(
   parameter int width = 32
) (
   input  logic [width-1:0] rem,
   input  logic [width-1:0] quo,
   input  logic [width-1:0] divisor,
   output logic [width-1:0] rem_next,
   output logic [width-1:0] quo_next
);

   logic [width:0] rem_shift;
   logic [width:0] trial;

   // A width+1 bit trial keeps the borrow, so its MSB is the sign of rem - divisor.
   always_comb begin
      rem_shift = {rem, quo[width-1]};
      trial     = rem_shift - {1'b0, divisor};
      if (!trial[width]) begin
         rem_next = trial[width-1:0];
         quo_next = {quo[width-2:0], 1'b1};
      end else begin
         rem_next = rem_shift[width-1:0];
         quo_next = {quo[width-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/mips_div_unit.sv
// Multi-cycle DIV/DIVU unit: magnitudes are divided one quotient bit per
// cycle, then the signs are applied in a final fix-up cycle. Lo = quotient,
// Hi = remainder.
module mips_div_unit
   import mips_div_unit_pkg::*;
#(
   parameter int width = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [width-1:0] A,
   input  logic [width-1:0] B,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [width-1:0] Hi,
   output logic [width-1:0] Lo
);

   localparam int CW = cnt_width(width);
   localparam logic [CW-1:0] LAST_ITER = CW'(width - 1);

   div_state_t       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [width-1:0] rem_q, rem_d;
   logic [width-1:0] quo_q, quo_d;
   logic [width-1:0] dvsr_q, dvsr_d;
   logic             q_neg_q, q_neg_d;
   logic             r_neg_q, r_neg_d;
   logic             div_zero_q, div_zero_d;
   logic [width-1:0] hi_q, hi_d;
   logic [width-1:0] lo_q, lo_d;
   logic             done_q, done_d;

   logic [width-1:0] step_rem;
   logic [width-1:0] step_quo;

   mips_div_unit_div_step #(.width(width)) u_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .divisor  (dvsr_q),
      .rem_next (step_rem),
      .quo_next (step_quo)
   );

   // Next-state logic: operand capture, iteration, sign fix-up, cancel.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      dvsr_d     = dvsr_q;
      q_neg_d    = q_neg_q;
      r_neg_d    = r_neg_q;
      div_zero_d = div_zero_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (cancel) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               rem_d = step_rem;
               quo_d = step_quo;
               if (cnt_q == LAST_ITER) begin
                  cnt_d   = '0;
                  state_d = ST_FIX;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_FIX: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            if (!cancel) begin
               lo_d   = q_neg_q ? -quo_q : quo_q;
               hi_d   = r_neg_q ? -rem_q : rem_q;
               done_d = 1'b1;
            end
         end
         default: begin
            // IDLE (and the unused encoding): start wins over cancel.
            if (start) begin
               // The dividend is loaded into the quotient register and shifted
               // out MSB-first into the partial remainder.
               quo_d      = (is_signed && A[width-1]) ? -A : A;
               dvsr_d     = (is_signed && B[width-1]) ? -B : B;
               q_neg_d    = is_signed && (A[width-1] ^ B[width-1]);
               r_neg_d    = is_signed && A[width-1];
               div_zero_d = (B == '0);
               rem_d      = '0;
               cnt_d      = '0;
               state_d    = ST_RUN;
            end
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         dvsr_q     <= '0;
         q_neg_q    <= 1'b0;
         r_neg_q    <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         dvsr_q     <= dvsr_d;
         q_neg_q    <= q_neg_d;
         r_neg_q    <= r_neg_d;
         div_zero_q <= div_zero_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         done_q     <= done_d;
      end
   end

   assign busy     = (state_q == ST_RUN) || (state_q == ST_FIX);
   assign done     = done_q;
   assign div_zero = div_zero_q;
   assign Hi       = hi_q;
   assign Lo       = lo_q;

endmodule

// File: tb/tb_mips_div_unit.sv
// Scoreboard bench for mips_div_unit: the driver pushes hand-computed
// results, a monitor pops and compares them whenever done pulses.
module tb_mips_div_unit;

   typedef struct {
      logic [31:0] lo;
      logic [31:0] hi;
      logic        dz;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        is_signed = 1'b0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        cancel = 1'b0;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] Hi;
   logic [31:0] Lo;

   int   tests = 0;
   int   fails = 0;
   exp_t exp_q[$];
   logic [31:0] last_lo = '0;
   logic [31:0] last_hi = '0;

   mips_div_unit dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .is_signed (is_signed),
      .A         (A),
      .B         (B),
      .cancel    (cancel),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero),
      .Hi        (Hi),
      .Lo        (Lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   // Monitor: every done pulse must match the oldest expected result.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("[TB] FAIL unexpected_done: got done=1 Lo=0x%08h Hi=0x%08h, expected no done", Lo, Hi);
            end else begin
               e = exp_q.pop_front();
               check("lo", Lo, e.lo);
               check("hi", Hi, e.hi);
               check("div_zero", {31'b0, div_zero}, {31'b0, e.dz});
               $display("[TB] result Lo=0x%08h Hi=0x%08h dz=%0b", Lo, Hi, div_zero);
            end
         end
      end
   end

   // Pulse start for one edge; leaves the bench at the negedge after it.
   task automatic pulse_start(input logic s, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; is_signed = s; A = a; B = b;
      @(negedge clk);
      start = 1'b0; A = $urandom; B = $urandom; is_signed = $urandom_range(0, 1);
   endtask

   // Full division: queues the expected result and checks latency and pulse width.
   task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e_lo, input logic [31:0] e_hi, input logic e_dz);
      exp_t e;
      int   busy_cycles = 0;
      int   n = 0;
      e.lo = e_lo; e.hi = e_hi; e.dz = e_dz;
      exp_q.push_back(e);
      $display("[TB] issue %s A=0x%08h B=0x%08h", s ? "DIV " : "DIVU", a, b);
      pulse_start(s, a, b);
      while (done !== 1'b1 && n < 100) begin
         if (busy === 1'b1) busy_cycles++;
         @(negedge clk);
         n++;
      end
      check("done_seen", {31'b0, done}, 32'd1);
      check("busy_cycles", busy_cycles, 32'd33);
      check("busy_low_at_done", {31'b0, busy}, 32'd0);
      @(negedge clk);
      check("done_one_cycle", {31'b0, done}, 32'd0);
      last_lo = e_lo; last_hi = e_hi;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_lo", Lo, 32'd0);
      check("rst_hi", Hi, 32'd0);

      do_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
      do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
      do_div(1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0);
      do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
      do_div(1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
      do_div(1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0);
      do_div(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
      do_div(1'b1, 32'hFFFF_FFFB, 32'd0, 32'h0000_0001, 32'hFFFF_FFFB, 1'b1);

      // Cancel mid-run, with an ignored start while busy.
      $display("[TB] issue DIVU 100/7 then cancel");
      pulse_start(1'b0, 32'd100, 32'd7);
      repeat (3) @(negedge clk);
      start = 1'b1; is_signed = 1'b0; A = 32'd9; B = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("busy_before_cancel", {31'b0, busy}, 32'd1);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      check("cancel_busy", {31'b0, busy}, 32'd0);
      check("cancel_done", {31'b0, done}, 32'd0);
      check("cancel_lo_kept", Lo, last_lo);
      check("cancel_hi_kept", Hi, last_hi);
      repeat (40) @(negedge clk);
      do_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

      // Reset in the middle of a division.
      $display("[TB] issue DIVU 100/7 then rst");
      pulse_start(1'b0, 32'd100, 32'd7);
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", {31'b0, busy}, 32'd0);
      check("midrst_done", {31'b0, done}, 32'd0);
      check("midrst_lo", Lo, 32'd0);
      check("midrst_hi", Hi, 32'd0);
      check("midrst_dz", {31'b0, div_zero}, 32'd0);
      repeat (40) @(negedge clk);
      do_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mips_div_unit.md
Name: mips_div_unit

Overview:
- Multi-cycle integer divider for the MIPS datapath. Executes DIV (signed) and DIVU (unsigned) with a restoring shift-subtract algorithm, one quotient bit per cycle.
- Results go to the HI/LO register pair: Lo = quotient, Hi = remainder.
- Sits beside the combinational ALU (32-bit logic/arith blocks) and is the sequential inverse of the multiply path.
- Control stalls on busy and captures results on done.

Parameters:
- width, 32, operand/result width in bits; iteration count equals width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a division; sampled only in IDLE.
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; captured with start.
- A  input  width  dividend; captured with start.
- B  input  width  divisor; captured with start.
- cancel  input  1  exception flush; aborts an in-flight division.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse: Hi/Lo valid.
- div_zero  output  1  divisor was zero; valid with done, held until next start.
- Hi  output  width  remainder.
- Lo  output  width  quotient.

Behaviour:
- Reset: one clock; synchronous, active-high reset.
  - At any edge with rst=1: state=IDLE, busy=0, done=0, div_zero=0, Hi=0, Lo=0, iteration counter=0.
  - rst overrides start and cancel, including mid-operation.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE:
  - start=1 at edge N captures A, B and is_signed.
  - Registers |A| and |B| when is_signed=1; raw values otherwise.
  - Records the quotient sign (A[msb]^B[msb]) and remainder sign (A[msb]), both qualified by is_signed.
  - Sets div_zero = (B==0), clears the partial remainder, goes to RUN, busy=1 from N+1.
- RUN:
  - Runs width iterations, edges N+1..N+width.
  - Each iteration: shift {rem, quo} left 1; trial = rem - divisor (width+1 bits); if trial is non-negative, rem = trial and quo LSB = 1, else quo LSB = 0.
  - Counter counts 0..width-1; at width-1 go to FIX.
- FIX, edge N+width+1:
  - Lo = quo, negated if the quotient sign is set.
  - Hi = rem, negated if the remainder sign is set.
  - done=1 and busy=0 in the cycle following this edge; go to IDLE.
  - Latency is width+1 edges after the start edge (33 for width=32).
- done is high exactly one cycle. Hi, Lo and div_zero hold until the next accepted start or rst.
- start while busy=1: ignored, with no effect on the operation in flight.
- start in the done cycle (state is IDLE): accepted normally.
- cancel=1 in RUN or FIX: return to IDLE at that edge, busy=0, no done pulse. Hi/Lo keep their previous values.
- cancel in IDLE: ignored. If start and cancel are both high in IDLE, start wins.
- Arithmetic rules:
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Signed 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0. No trap; this falls out of the magnitude algorithm.
- Divide by zero: runs the full latency without early exit.
  - Natural result in unsigned magnitude: Lo=all ones, Hi=|A|.
  - Sign fix-up applies as normal; div_zero=1.
- Operand inputs are ignored after capture; changing A/B mid-operation has no effect.

Decomposition:
- Shared package:
  - DIV_WIDTH constant.
  - State encoding: IDLE=2'b00, RUN=2'b01, FIX=2'b10; 2'b11 decodes to IDLE.
  - Counter width = clog2(DIV_WIDTH).
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once inside mips_div_unit.

Test Plan:
- DIVU A=100, B=7, start pulse -> busy for 33 cycles, then done=1 one cycle with Lo=14, Hi=2, div_zero=0.
- DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1). Same operands as DIVU -> Lo=0x7FFFFFFC, Hi=1.
- DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0, no hang, done after 33 cycles.
- DIVU A=0x12345678, B=0 -> Lo=0xFFFFFFFF, Hi=0x12345678, div_zero=1, normal latency.
- Start 100/7, re-pulse start with 9/3 at cycle 5, assert cancel at cycle 10 -> no done, busy=0 next cycle, Hi/Lo unchanged. New start then gives 9/3 -> Lo=3, Hi=0.
- rst at cycle 20 of a division -> next cycle busy=0, done=0, Hi=Lo=0, div_zero=0. Subsequent start completes correctly.
